// File: rtl/controlador_de_interrupcao.sv
// Interrupt controller and preemption scheduler for the iZero processor.
// Latches device/disk/quantum requests, arbitrates by fixed priority and holds code/PC for the kernel.
module controlador_de_interrupcao #(
  parameter int QUANTUM = 1000,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              userMode,
  input  logic              kernelMode,
  input  logic              inta,
  input  logic              clearIntr,
  input  logic              inputReq,
  input  logic              diskReq,
  input  logic [DATA_W-1:0] pcIn,
  output logic              intr,
  output logic [DATA_W-1:0] intCode,
  output logic [DATA_W-1:0] intPc
);

  localparam int TW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(QUANTUM - 1);
  localparam int NSRC = 3;  // bit 0 input, bit 1 disk, bit 2 timer (also priority order)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                mode_reg, mode_next;
  logic [TW-1:0]       timer_reg, timer_next;
  logic                timer_wrap;
  logic [1:0]          prev_reg;
  logic [1:0]          req_vec;
  logic [1:0]          rise;
  logic [NSRC-1:0]     pend_reg, pend_next;
  logic [NSRC-1:0]     grant_raw;
  logic [NSRC-1:0]     grant;
  logic                arb;
  logic                ack;
  logic                intr_reg, intr_next;
  logic [1:0]          code_reg, code_next;
  logic [1:0]          code_sel;
  logic [DATA_W-1:0]   pc_reg, pc_next;

  assign req_vec = {diskReq, inputReq};

  // Rising-edge detection per external request line.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      assign rise[gi] = req_vec[gi] & ~prev_reg[gi];
    end
  endgenerate

  // A source wins only if no lower-numbered (higher-priority) source is pending.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_prio
      assign grant_raw[gi] = pend_reg[gi] & ~(|(pend_reg & ((NSRC'(1) << gi) - NSRC'(1))));
    end
  endgenerate

  assign code_sel = {grant_raw[2] | grant_raw[1], grant_raw[2] | grant_raw[0]};

  // FSM next-state and datapath updates.
  always_comb begin
    state_next = state_reg;
    intr_next  = intr_reg;
    code_next  = code_reg;
    pc_next    = pc_reg;
    arb        = 1'b0;
    ack        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (mode_reg && (|pend_reg)) begin
          arb        = 1'b1;
          code_next  = code_sel;
          intr_next  = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (inta) begin
          ack        = 1'b1;
          pc_next    = pcIn;
          intr_next  = 1'b0;
          state_next = SVC;
        end
      end
      SVC: begin
        if (clearIntr) begin
          code_next  = 2'd0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        intr_next  = 1'b0;
        code_next  = 2'd0;
      end
    endcase
  end

  // Quantum timer: counts only in user mode while nothing is being serviced.
  always_comb begin
    timer_next = timer_reg;
    timer_wrap = 1'b0;
    if (userMode) begin
      timer_next = '0;
    end else if (mode_reg && (state_reg == IDLE)) begin
      if (timer_reg == T_LAST) begin
        timer_next = '0;
        timer_wrap = 1'b1;
      end else begin
        timer_next = timer_reg + TW'(1);
      end
    end
  end

  always_comb begin
    mode_next = mode_reg;
    if (userMode) begin
      mode_next = 1'b1;
    end else if (kernelMode || ack) begin
      mode_next = 1'b0;
    end
  end

  // New events are ORed in after the arbitration clear so a coincident set wins.
  assign grant     = arb ? grant_raw : '0;
  assign pend_next = (pend_reg & ~grant) | {timer_wrap, rise};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg  <= 1'b0;
      timer_reg <= '0;
      prev_reg  <= '0;
      pend_reg  <= '0;
      intr_reg  <= 1'b0;
      code_reg  <= 2'd0;
      pc_reg    <= '0;
    end else begin
      mode_reg  <= mode_next;
      timer_reg <= timer_next;
      prev_reg  <= req_vec;
      pend_reg  <= pend_next;
      intr_reg  <= intr_next;
      code_reg  <= code_next;
      pc_reg    <= pc_next;
    end
  end

  assign intr    = intr_reg;
  assign intCode = {{(DATA_W-2){1'b0}}, code_reg};
  assign intPc   = pc_reg;

endmodule

// File: tb/tb_controlador_de_interrupcao.sv
// Directed bench for controlador_de_interrupcao with QUANTUM = 8.
module tb_controlador_de_interrupcao;

  logic        clk = 1'b0;
  logic        rst;
  logic        userMode, kernelMode, inta, clearIntr, inputReq, diskReq;
  logic [31:0] pcIn;
  logic        intr;
  logic [31:0] intCode, intPc;

  int checks = 0;
  int errors = 0;

  controlador_de_interrupcao #(.QUANTUM(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .userMode(userMode), .kernelMode(kernelMode),
    .inta(inta), .clearIntr(clearIntr), .inputReq(inputReq), .diskReq(diskReq),
    .pcIn(pcIn), .intr(intr), .intCode(intCode), .intPc(intPc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
    $display("check %-22s observed %h expected %h", tag, observed, expected);
  endtask

  task automatic pulse_user();
    userMode = 1'b1; tick(); userMode = 1'b0;
  endtask

  task automatic do_inta(input logic [31:0] pc);
    pcIn = pc; inta = 1'b1; tick(); inta = 1'b0;
  endtask

  task automatic do_clear();
    clearIntr = 1'b1; tick(); clearIntr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; userMode = 0; kernelMode = 0; inta = 0; clearIntr = 0;
    inputReq = 0; diskReq = 0; pcIn = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_intr", {31'b0, intr}, 32'd0);
    check("reset_code", intCode, 32'd0);
    check("reset_pc", intPc, 32'd0);

    // Single input interrupt
    pulse_user();
    inputReq = 1'b1;
    tick();
    check("in_edge1_intr", {31'b0, intr}, 32'd0);
    tick();
    check("in_edge2_intr", {31'b0, intr}, 32'd1);
    check("in_edge2_code", intCode, 32'd1);
    tick();
    check("in_req_hold", {31'b0, intr}, 32'd1);
    do_inta(32'h0000_0040);
    check("in_ack_intr", {31'b0, intr}, 32'd0);
    check("in_ack_pc", intPc, 32'h40);
    check("in_svc_code", intCode, 32'd1);
    pcIn = 32'h0000_0099;
    tick();
    check("in_svc_pc_stable", intPc, 32'h40);
    do_clear();
    check("in_clear_code", intCode, 32'd0);

    // Held level across clear: no second interrupt even in user mode
    pulse_user();
    tick(); tick(); tick();
    check("held_level_intr", {31'b0, intr}, 32'd0);
    kernelMode = 1'b1; tick(); kernelMode = 1'b0;
    inputReq = 1'b0;

    // Stray inta / clearIntr in IDLE
    pcIn = 32'h0000_0077;
    inta = 1'b1; clearIntr = 1'b1; tick(); inta = 1'b0; clearIntr = 1'b0;
    tick();
    check("stray_intr", {31'b0, intr}, 32'd0);
    check("stray_code", intCode, 32'd0);
    check("stray_pc", intPc, 32'h40);

    // Priority: input and disk rise together
    pulse_user();
    inputReq = 1'b1; diskReq = 1'b1;
    tick(); tick();
    check("prio_first_intr", {31'b0, intr}, 32'd1);
    check("prio_first_code", intCode, 32'd1);
    do_inta(32'h0000_0100);
    check("prio_ack_pc", intPc, 32'h100);
    do_clear();
    tick();
    check("prio_kernel_wait", {31'b0, intr}, 32'd0);
    pulse_user();
    check("prio_user_edge", {31'b0, intr}, 32'd0);
    tick();
    check("prio_second_intr", {31'b0, intr}, 32'd1);
    check("prio_second_code", intCode, 32'd2);
    do_inta(32'h0000_0104);
    do_clear();
    inputReq = 1'b0; diskReq = 1'b0;
    tick();

    // Kernel masking
    diskReq = 1'b1;
    tick(); tick(); tick();
    check("mask_intr", {31'b0, intr}, 32'd0);
    pulse_user();
    check("mask_user_edge", {31'b0, intr}, 32'd0);
    tick();
    check("mask_served_intr", {31'b0, intr}, 32'd1);
    check("mask_served_code", intCode, 32'd2);
    do_inta(32'h0000_0108);
    do_clear();
    diskReq = 1'b0;
    tick();

    // Quantum expiry: pulse at edge 0, pend_timer at edge 8, intr at edge 9
    pulse_user();
    for (int i = 1; i <= 8; i++) tick();
    check("q_edge8_intr", {31'b0, intr}, 32'd0);
    tick();
    check("q_edge9_intr", {31'b0, intr}, 32'd1);
    check("q_edge9_code", intCode, 32'd3);
    do_inta(32'h0000_0200);
    check("q_ack_pc", intPc, 32'h200);
    do_clear();
    check("q_clear_code", intCode, 32'd0);

    // Quantum frozen by kernelMode at cycle 4
    pulse_user();
    tick(); tick(); tick();
    kernelMode = 1'b1; tick(); kernelMode = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("q_frozen_intr", {31'b0, intr}, 32'd0);
    check("q_frozen_code", intCode, 32'd0);

    // Asynchronous reset while intr is high, with a disk event pending
    pulse_user();
    inputReq = 1'b1;
    tick(); tick();
    check("rst_pre_intr", {31'b0, intr}, 32'd1);
    diskReq = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_async_intr", {31'b0, intr}, 32'd0);
    check("rst_async_code", intCode, 32'd0);
    check("rst_async_pc", intPc, 32'd0);
    inputReq = 1'b0; diskReq = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("rst_after_intr", {31'b0, intr}, 32'd0);
    pulse_user();
    tick(); tick();
    check("rst_pending_dropped", {31'b0, intr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_de_interrupcao.md
# controlador_de_interrupcao

Interrupt controller and preemption scheduler for the iZero processor. It latches requests from the input device, the disk, and a quantum timer. It arbitrates them by fixed priority and raises `intr` to the control unit while a user program is running. It then holds the interrupt code and the interrupted PC until the kernel reads them (`gic`/`gip` path) and clears them (`cic` → `clearIntr`).

## Interface
Parameters:
- `QUANTUM`, 1000: user-mode cycles per time slice; legal range ≥ 2.
- `DATA_W`, 32: width of `pcIn`, `intPc` and `intCode`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `userMode`  in  1  one-cycle pulse from control unit (`exec`/`exec_again`); enters user mode and restarts the quantum.
- `kernelMode`  in  1  one-cycle pulse (`syscall`); enters kernel mode.
- `inta`  in  1  interrupt acknowledge from control unit (`pre_io`).
- `clearIntr`  in  1  clears the held code (`cic`).
- `inputReq`  in  1  input-device request; a level, and the rising edge is the event.
- `diskReq`  in  1  disk-done request; a level, and the rising edge is the event.
- `pcIn`  in  DATA_W  PC of the instruction in execution.
- `intr`  out  1  interrupt request to the control unit.
- `intCode`  out  DATA_W  held code, zero-extended: 0 none, 1 input, 2 disk, 3 timer.
- `intPc`  out  DATA_W  `pcIn` captured at acknowledge.

## Operation
**Request capture**
- Each of `inputReq` and `diskReq` has a previous-sample register.
- A sample that is 1 while the previous sample is 0 sets the pending bit for that source.
- Pending bits are sticky. Only arbitration clears them.

**Mode flag**
- `userMode` sets the flag. `kernelMode` or an accepted `inta` clears it.
- If `userMode` and `kernelMode` are both asserted, `userMode` wins.

**Quantum timer**
- Width is `$clog2(QUANTUM)`.
- `userMode` loads 0.
- While the mode flag is 1 and the state is IDLE, the timer increments each cycle.
- At the value `QUANTUM-1` it wraps to 0 and sets `pend_timer`.
- The timer holds its value in kernel mode and outside IDLE.

**FSM**
- **IDLE**
  - Taken when the mode flag is 1 and any pending bit is 1.
  - Selects the highest-priority source: input > disk > timer.
  - Loads its code into `intCode` and clears that one pending bit.
  - Sets `intr` = 1 and moves to REQ.
- **REQ**
  - `intr` stays 1 until `inta`.
  - On `inta`: `intPc` ← `pcIn`, `intr` ← 0, mode flag ← 0, move to SVC.
- **SVC**
  - `intCode` and `intPc` are held stable.
  - On `clearIntr`: `intCode` ← 0 and move to IDLE. `intPc` is kept.
- `inta` outside REQ is ignored. `clearIntr` outside SVC is ignored.

**Simultaneous events**
- When a new request edge and arbitration's clear hit the same bit in one cycle, the set wins. The new event is not lost.
- Requests arriving during REQ or SVC stay pending. They are served after the next `userMode`.
- The remaining pending sources are served in priority order on later returns to user mode.

## Timing
- Reset value of every output and register is 0. State is IDLE and the mode flag is 0.
- Reset mid-operation drops all pending, held and timer state immediately.
- **Request-to-`intr` latency:** 2 edges in user mode.
  - Edge 1: the request is sampled and the pending bit is set.
  - Edge 2: arbitration loads `intCode` and raises `intr`.
  - `intCode` is valid in the same cycle `intr` is high.
- `inta` is sampled at an edge. `intr` falls and `intPc` updates at that edge, with zero added latency.
- `clearIntr` takes effect at its edge. A pending source can re-raise `intr` at the next edge only if the mode flag is 1.
- **Timer period:** exactly `QUANTUM` user-mode IDLE cycles from `userMode` to `pend_timer` set. The interrupt follows one edge later.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle with `intr` = 1 → all outputs 0 immediately; after release no interrupt appears without a new `userMode` pulse.
- **Single input interrupt:** `userMode` pulse, then `inputReq` 0→1 → `intr` = 1 two edges later with `intCode` = 1. `inta` with `pcIn` = 0x0000_0040 → `intr` = 0 and `intPc` = 0x40. `clearIntr` → `intCode` = 0.
- **Priority:** in user mode, `inputReq` and `diskReq` rise in the same cycle → `intCode` = 1 first. After `clearIntr` and a `userMode` pulse → `intCode` = 2. The disk request is not lost.
- **Quantum:** `QUANTUM` = 8, `userMode` pulse with no other requests → `intr` rises at edge 9 after the pulse with `intCode` = 3. A `kernelMode` pulse at cycle 4 → the timer freezes and no interrupt occurs.
- **Kernel masking:** `diskReq` rises while the mode flag is 0 → no `intr`. A later `userMode` pulse → `intr` with `intCode` = 2 two edges later.
- **Held-level and stray controls:** hold `inputReq` high across `clearIntr` → no second interrupt. `inta` and `clearIntr` pulsed in IDLE → no state change.
